voice_scheduler: RTL and testbench
==================================

Name: voice_scheduler

Overview:
- Allocates incoming notes from the song reader to a pool of NUM_VOICES sine voices and owns each voice's duration countdown.
- Accepts one note per valid/ready handshake, picks a free voice, and issues a registered one-hot load strobe with the note number to that voice's frequency register.
- Decrements each voice's remaining count on the 1/48 s beat and reports busy/idle status.
- Sits between the song reader and the per-voice frequency_rom/sine_reader chains; the adder mixes voice outputs downstream.

Parameters:
- NUM_VOICES, 3, number of voice slots.
- NOTE_W, 6, note number width.
- DUR_W, 6, duration width in beats.
- STEAL, 0, 1 = when all voices are busy, preempt the voice with the smallest remaining count; 0 = stall.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play_enable  in  1  high = run; low = freeze counters and refuse requests
- beat  in  1  one-cycle 1/48 s tick
- flush  in  1  one-cycle pulse; frees all voices
- req_valid  in  1  note request present
- req_note  in  NOTE_W  note to play
- req_duration  in  DUR_W  duration in beats
- req_ready  out  1  scheduler can accept this cycle
- voice_load  out  NUM_VOICES  one-hot load strobe, one cycle
- voice_note  out  NOTE_W  note for the strobed voice
- voice_busy  out  NUM_VOICES  bit i = remaining[i] != 0
- active_count  out  2 (clog2(NUM_VOICES+1))  number of busy voices
- all_idle  out  1  no voice busy and no load pending

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-high.
- Reset values:
  - remaining[] = 0
  - voice_load = 0, voice_note = 0
  - voice_busy = 0, active_count = 0
  - all_idle = 1
  - req_ready = 0 while reset is asserted.
- Readiness: req_ready = play_enable && !flush && (any voice free || STEAL). It is combinational from registered state and never depends on req_valid.
- Accept: accept = req_valid && req_ready.
- Victim selection on accept:
  - The lowest-index voice with remaining == 0.
  - If none is free and STEAL=1: the voice with minimum remaining; ties go to the lowest index.
- Update on the accept cycle:
  - remaining[victim] <= req_duration.
  - Next cycle: voice_load = onehot(victim) for exactly one cycle, voice_note = req_note (latency 1).
  - voice_note holds its value until the next load.
- Zero duration: a request with req_duration == 0 is accepted and consumed, but produces no load strobe and no counter change.
- Beat: when beat && play_enable, every nonzero remaining[i] decrements by 1. A zero counter stays 0 and never wraps.
- Simultaneous load and beat on the same voice: the load wins. remaining = req_duration, with no decrement that cycle. Other voices still decrement.
- Voice freed on the same cycle as a request: a voice reaching 0 on a beat is seen as free only from the next cycle, because selection uses registered counts.
- play_enable low:
  - Counters freeze.
  - req_ready = 0.
  - A voice_load already registered still fires.
- Flush:
  - All remaining[] clear next cycle.
  - Flush takes priority over accept and beat; req_ready = 0 during the flush cycle.
  - A pending voice_load from the prior cycle still fires.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). A pending strobe is dropped.
- Status outputs:
  - voice_busy, active_count and all_idle derive from registered state.
  - all_idle = (active_count == 0) && !(|voice_load).

Decomposition:
- Shared package holds:
  - NOTE_W and DUR_W defaults;
  - NUM_VOICES default;
  - the clog2 helper for active_count width.
- Sub-module voice_slot_counter: per-voice DUR_W down-counter with load/dec/clear, load priority over decrement, saturation at 0, and a busy output. It is instantiated NUM_VOICES times.
- Victim select and handshake stay in the top.

Test Plan:
- Fill and stall: reset, play_enable=1, STEAL=0; send notes 10/20/30, duration 4 each, on consecutive cycles.
  - Expect voice_load 001, 010, 100, each one cycle after accept; voice_note 10, 20, 30.
  - A fourth request sees req_ready=0; active_count=3.
- Countdown: continuing the fill scenario, issue 4 beats.
  - Expect voice_busy 111 after 3 beats and 000 after the 4th; all_idle=1.
  - The stalled request is then accepted into voice 0.
- Steal: STEAL=1, voices loaded with 5/2/7, then a new note 40 duration 3.
  - Expect voice_load=010, voice_note=40, remaining[1]=3.
- Load vs beat: beat and accept to free voice 0 with duration 6 in the same cycle, while voice 1 holds 3.
  - Expect remaining[0]=6 and remaining[1]=2.
- Freeze and flush: play_enable=0 with beats for 10 cycles.
  - Counts unchanged; req_ready=0.
  - Then flush=1: voice_busy=000 next cycle.
- Zero duration and async reset:
  - A duration-0 request is accepted with no voice_load.
  - Asserting reset mid-strobe clears voice_load and all counts immediately.

Source files
------------

// File: rtl/voice_scheduler_pkg.sv
// Shared defaults and helpers for the voice scheduler and its per-voice counters.
package voice_scheduler_pkg;

    localparam int unsigned NUM_VOICES_DEF = 3;
    localparam int unsigned NOTE_W_DEF     = 6;
    localparam int unsigned DUR_W_DEF      = 6;

    // Ceiling log2 with a floor of 1, so single-entry vectors still get one bit.
    function automatic int unsigned clog2_u(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = 32'(i) + 32'd1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/voice_slot_counter.sv
// Per-voice remaining-duration down-counter.
// Ports: clk/reset (async, active-high); clear frees the voice; load sets
// load_val; dec subtracts one beat; count is the registered remaining value;
// busy is high while count is nonzero.
// Priority: clear > load > dec. A zero count never wraps.
module voice_slot_counter
    import voice_scheduler_pkg::*;
#(
    parameter int unsigned DUR_W = DUR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [DUR_W-1:0] load_val,
    input  logic             dec,
    output logic [DUR_W-1:0] count,
    output logic             busy
);

    logic [DUR_W-1:0] count_q;
    logic [DUR_W-1:0] count_d;

    // Next-count selection.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - DUR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign busy  = (count_q != '0);

endmodule

// File: rtl/voice_scheduler.sv
// Allocates note requests to a pool of voices and tracks each voice's duration.
// Ports: clk/reset (async, active-high); play_enable runs/freezes the pool;
// beat is the 1/48 s tick; flush frees every voice; req_valid/req_note/
// req_duration with req_ready form the request handshake; voice_load is a
// one-cycle one-hot strobe with voice_note for the loaded voice; voice_busy,
// active_count and all_idle report pool occupancy.
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_VOICES = NUM_VOICES_DEF,
    parameter  int unsigned NOTE_W     = NOTE_W_DEF,
    parameter  int unsigned DUR_W      = DUR_W_DEF,
    parameter  int unsigned STEAL      = 0,
    localparam int unsigned CNT_W      = clog2_u(NUM_VOICES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  beat,
    input  logic                  flush,
    input  logic                  req_valid,
    input  logic [NOTE_W-1:0]     req_note,
    input  logic [DUR_W-1:0]      req_duration,
    output logic                  req_ready,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_W-1:0]     voice_note,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic [CNT_W-1:0]      active_count,
    output logic                  all_idle
);

    localparam int unsigned VIDX_W = clog2_u(NUM_VOICES);

    logic [DUR_W-1:0]      count_arr [NUM_VOICES];
    logic [NUM_VOICES-1:0] busy_vec;
    logic [NUM_VOICES-1:0] load_vec;

    logic [VIDX_W-1:0]     free_idx;
    logic [VIDX_W-1:0]     min_idx;
    logic [VIDX_W-1:0]     victim;
    logic [DUR_W-1:0]      min_val;
    logic                  any_free;
    logic                  accept;
    logic                  do_load;
    logic                  dec_all;
    logic [CNT_W-1:0]      active_c;

    logic [NUM_VOICES-1:0] voice_load_q;
    logic [NUM_VOICES-1:0] voice_load_d;
    logic [NOTE_W-1:0]     voice_note_q;
    logic [NOTE_W-1:0]     voice_note_d;

    // Victim choice: lowest free voice, else (stealing) smallest remaining, lowest index on ties.
    always_comb begin
        any_free = ~(&busy_vec);
        free_idx = '0;
        for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_idx = VIDX_W'(i);
            end
        end
        min_idx = '0;
        min_val = count_arr[0];
        for (int i = 1; i < int'(NUM_VOICES); i++) begin
            if (count_arr[i] < min_val) begin
                min_val = count_arr[i];
                min_idx = VIDX_W'(i);
            end
        end
        victim = any_free ? free_idx : min_idx;
    end

    // Handshake; selection only looks at registered counts, so a voice freed by
    // this cycle's beat becomes eligible next cycle.
    always_comb begin
        req_ready = !reset && play_enable && !flush && (any_free || (STEAL != 0));
        accept    = req_valid && req_ready;
        do_load   = accept && (req_duration != '0);
        dec_all   = beat && play_enable && !flush;
    end

    // Load strobe and held note for the downstream frequency registers.
    always_comb begin
        voice_load_d = '0;
        voice_note_d = voice_note_q;
        if (do_load) begin
            voice_load_d = NUM_VOICES'(1) << victim;
            voice_note_d = req_note;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            voice_load_q <= '0;
            voice_note_q <= '0;
        end else begin
            voice_load_q <= voice_load_d;
            voice_note_q <= voice_note_d;
        end
    end

    for (genvar g = 0; g < int'(NUM_VOICES); g++) begin : g_slot
        assign load_vec[g] = do_load && (victim == VIDX_W'(g));

        voice_slot_counter #(
            .DUR_W(DUR_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .clear   (flush),
            .load    (load_vec[g]),
            .load_val(req_duration),
            .dec     (dec_all),
            .count   (count_arr[g]),
            .busy    (busy_vec[g])
        );
    end

    // Occupancy count.
    always_comb begin
        active_c = '0;
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
            active_c = active_c + CNT_W'(busy_vec[i]);
        end
    end

    assign voice_load   = voice_load_q;
    assign voice_note   = voice_note_q;
    assign voice_busy   = busy_vec;
    assign active_count = active_c;
    assign all_idle     = (active_c == '0) && !(|voice_load_q);

endmodule

// File: tb/tb_voice_scheduler.sv
// Randomized and directed checks of voice_scheduler (stall and steal builds)
// against a per-voice remaining-count model.
module tb_voice_scheduler;

    localparam int NV = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic play_enable = 1'b0;
    logic beat = 1'b0;
    logic flush = 1'b0;
    logic req_valid = 1'b0;
    logic [5:0] req_note = '0;
    logic [5:0] req_duration = '0;

    logic       rdy    [2];
    logic [2:0] vload  [2];
    logic [5:0] vnote  [2];
    logic [2:0] vbusy  [2];
    logic [1:0] acount [2];
    logic       idle   [2];

    int n_tests = 0;
    int n_fail  = 0;

    int rem      [2][NV];
    int exp_load [2];
    int exp_note [2];

    always #5 clk = ~clk;

    voice_scheduler #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .STEAL(0)) u_dut_stall (
        .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat), .flush(flush),
        .req_valid(req_valid), .req_note(req_note), .req_duration(req_duration),
        .req_ready(rdy[0]), .voice_load(vload[0]), .voice_note(vnote[0]),
        .voice_busy(vbusy[0]), .active_count(acount[0]), .all_idle(idle[0])
    );

    voice_scheduler #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6), .STEAL(1)) u_dut_steal (
        .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat), .flush(flush),
        .req_valid(req_valid), .req_note(req_note), .req_duration(req_duration),
        .req_ready(rdy[1]), .voice_load(vload[1]), .voice_note(vnote[1]),
        .voice_busy(vbusy[1]), .active_count(acount[1]), .all_idle(idle[1])
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NV; i++) rem[d][i] = 0;
            exp_load[d] = 0;
            exp_note[d] = 0;
        end
    endtask

    // Compare the registered/status outputs against the model state.
    task automatic check_state(input int d);
        int busy_bits;
        int nbusy;
        busy_bits = 0;
        nbusy = 0;
        for (int i = 0; i < NV; i++) begin
            if (rem[d][i] != 0) begin
                busy_bits |= (1 << i);
                nbusy++;
            end
        end
        check_eq($sformatf("d%0d voice_load", d), int'(vload[d]), exp_load[d]);
        check_eq($sformatf("d%0d voice_note", d), int'(vnote[d]), exp_note[d]);
        check_eq($sformatf("d%0d voice_busy", d), int'(vbusy[d]), busy_bits);
        check_eq($sformatf("d%0d active_count", d), int'(acount[d]), nbusy);
        check_eq($sformatf("d%0d all_idle", d), int'(idle[d]),
                 ((nbusy == 0) && (exp_load[d] == 0)) ? 1 : 0);
    endtask

    // One clock of stimulus: check current state, drive inputs, check ready, advance model.
    task automatic step(input bit pe, input bit bt, input bit fl, input bit vld,
                        input int note, input int dur);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_state(d);
        play_enable  = pe;
        beat         = bt;
        flush        = fl;
        req_valid    = vld;
        req_note     = 6'(note);
        req_duration = 6'(dur);
        #1;
        for (int d = 0; d < 2; d++) begin
            bit any_free;
            bit exp_rdy;
            int v;
            any_free = 1'b0;
            for (int i = 0; i < NV; i++) if (rem[d][i] == 0) any_free = 1'b1;
            exp_rdy = pe && !fl && (any_free || (d == 1));
            check_eq($sformatf("d%0d req_ready", d), int'(rdy[d]), int'(exp_rdy));
            exp_load[d] = 0;
            if (fl) begin
                for (int i = 0; i < NV; i++) rem[d][i] = 0;
            end else if (pe) begin
                v = -1;
                if (vld && exp_rdy) begin
                    for (int i = NV - 1; i >= 0; i--) if (rem[d][i] == 0) v = i;
                    if (v < 0) begin
                        v = 0;
                        for (int i = 1; i < NV; i++) if (rem[d][i] < rem[d][v]) v = i;
                    end
                end
                for (int i = 0; i < NV; i++) begin
                    if (bt && rem[d][i] > 0 && !(i == v && dur != 0)) rem[d][i]--;
                end
                if (v >= 0 && dur != 0) begin
                    rem[d][v]    = dur;
                    exp_load[d]  = 1 << v;
                    exp_note[d]  = note;
                end
            end
        end
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock.
    task automatic async_reset();
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_state(d);
        req_valid = 1'b0;
        beat      = 1'b0;
        flush     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d rst voice_load", d), int'(vload[d]), 0);
            check_eq($sformatf("d%0d rst voice_note", d), int'(vnote[d]), 0);
            check_eq($sformatf("d%0d rst voice_busy", d), int'(vbusy[d]), 0);
            check_eq($sformatf("d%0d rst active_count", d), int'(acount[d]), 0);
            check_eq($sformatf("d%0d rst all_idle", d), int'(idle[d]), 1);
            check_eq($sformatf("d%0d rst req_ready", d), int'(rdy[d]), 0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        play_enable = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("d%0d in-reset req_ready", d), int'(rdy[d]), 0);
            check_eq($sformatf("d%0d in-reset all_idle", d), int'(idle[d]), 1);
        end
        @(negedge clk);
        reset = 1'b0;

        // Fill, stall (steal build takes voice 0), then count down.
        step(1, 0, 0, 1, 10, 4);
        step(1, 0, 0, 1, 20, 4);
        step(1, 0, 0, 1, 30, 4);
        step(1, 0, 0, 1, 33, 4);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 1, 33, 4);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Freeze with beats, then flush.
        for (int k = 0; k < 10; k++) step(0, 1, 0, 1, 44, 2);
        step(1, 0, 1, 1, 45, 2);
        step(1, 0, 0, 0, 0, 0);

        // Steal the smallest remaining (5/2/7 -> voice 1).
        step(1, 0, 0, 1, 1, 5);
        step(1, 0, 0, 1, 2, 2);
        step(1, 0, 0, 1, 3, 7);
        step(1, 0, 0, 1, 40, 3);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);

        // Load versus beat on the same voice.
        step(1, 0, 0, 1, 4, 1);
        step(1, 0, 0, 1, 5, 4);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 50, 6);
        step(1, 0, 0, 0, 0, 0);

        // Zero-duration request, then reset during a strobe.
        step(1, 0, 0, 1, 9, 0);
        step(1, 0, 0, 1, 12, 3);
        async_reset();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            int dur;
            dur = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 63))
                                                : int'($urandom_range(0, 6));
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1,
                     int'($urandom_range(0, 63)), dur);
            end
        end
        step(1, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
